// File: rtl/fifo_frame_reader_pkg.sv
// fifo_utilities: shared types and defaults for the ADC FIFO writer/reader pair.
//   fifo_signals_t    - write-side FIFO bundle (clk, req, full, data)
//   fifo_rd_signals_t - read-side FIFO bundle (clk, req, empty, full, q)
//   rd_state_e        - frame reader FSM states
//   ADC_WORD_W / ADC_CHANNELS - default word width and words per frame
package fifo_utilities;
  localparam int ADC_WORD_W   = 64;
  localparam int ADC_CHANNELS = 4;

  typedef struct packed {
    logic                  clk;
    logic                  req;
    logic                  full;
    logic [ADC_WORD_W-1:0] data;
  } fifo_signals_t;

  typedef struct packed {
    logic                  clk;
    logic                  req;
    logic                  empty;
    logic                  full;
    logic [ADC_WORD_W-1:0] q;
  } fifo_rd_signals_t;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } rd_state_e;
endpackage

// File: rtl/fifo_frame_reader_read_pipe.sv
// fifo_read_pipe: valid shift register that delays each accepted FIFO read
// request by the FIFO's read latency, producing the strobe on which Q is valid.
//   clk_i  - read clock
//   rst_ni - async active-low reset
//   req_i  - accepted read request this cycle
//   cap_o  - Q holds the word for a request issued STAGES cycles ago
module fifo_read_pipe #(
  parameter int STAGES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic cap_o
);
  logic [STAGES-1:0] vld_pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= req_i;
      for (int i = 1; i < STAGES; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign cap_o = vld_pipe_q[STAGES-1];
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains the read port of the ADC FIFO and reassembles
// WORDS consecutive words into one frame handed out over valid/ready.
//   CLK, nRST            - read clock, async active-low reset
//   RDEMPTY, RDFULL, Q   - FIFO read-side status and data
//   RDREQ                - FIFO pop request (never asserted while RDEMPTY)
//   FRAME, FRAME_VALID   - assembled frame (FRAME[0] = first word read)
//   FRAME_READY          - consumer accept
//   STALL                - partial frame starved for STALL_TIMEOUT cycles
//   OVERRUN_SEEN         - sticky RDFULL observation
// Optional (FIFO_READER_STATS_EN): FRAME_COUNT (handshakes, wrapping) and
// STALL_COUNT (STALL rising edges, saturating).
module fifo_frame_reader import fifo_utilities::*; #(
  parameter int WIDTH         = ADC_WORD_W,
  parameter int WORDS         = ADC_CHANNELS,
  parameter int READ_LATENCY  = 1,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         RDEMPTY,
  input  logic                         RDFULL,
  input  logic [WIDTH-1:0]             Q,
  output logic                         RDREQ,
  output logic [WORDS-1:0][WIDTH-1:0]  FRAME,
  output logic                         FRAME_VALID,
  input  logic                         FRAME_READY,
  output logic                         STALL,
  output logic                         OVERRUN_SEEN
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]                  FRAME_COUNT,
  output logic [15:0]                  STALL_COUNT
`endif
);
  localparam int CW = $clog2(WORDS + 1);
  localparam int TW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
  localparam logic [CW-1:0] LAST_C  = CW'(WORDS - 1);
  localparam logic [TW-1:0] TMAX_C  = TW'(STALL_TIMEOUT);

  rd_state_e                  state_q, state_d;
  logic [CW-1:0]              issued_q, issued_d, captured_q, captured_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [WORDS-1:0][WIDTH-1:0] frame_q, frame_d;
  logic                       overrun_q;
  logic                       cap;

  fifo_read_pipe #(.STAGES(READ_LATENCY)) u_read_pipe (
    .clk_i (CLK),
    .rst_ni(nRST),
    .req_i (RDREQ),
    .cap_o (cap)
  );

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    timer_d    = timer_q;
    frame_d    = frame_q;
    RDREQ      = 1'b0;
    case (state_q)
      FILL: begin
        RDREQ = !RDEMPTY && (issued_q < WORDS_C);
        if (RDREQ) issued_d = issued_q + 1'b1;
        if (cap) begin
          for (int i = 0; i < WORDS; i++)
            if (captured_q == CW'(i)) frame_d[i] = Q;
          timer_d = '0;
          // The last capture always trails the last issue, so clearing
          // issued here cannot drop a request made in the same cycle.
          if (captured_q == LAST_C) begin
            state_d    = PRESENT;
            issued_d   = '0;
            captured_d = '0;
          end else begin
            captured_d = captured_q + 1'b1;
          end
        end else if (!RDREQ && captured_q != '0 && timer_q != TMAX_C) begin
          timer_d = timer_q + 1'b1;
        end
      end
      PRESENT: begin
        timer_d = '0;
        if (FRAME_READY) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FILL;
      issued_q   <= '0;
      captured_q <= '0;
      timer_q    <= '0;
      frame_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      timer_q    <= timer_d;
      frame_q    <= frame_d;
      if (RDFULL) overrun_q <= 1'b1;
    end
  end

  assign FRAME        = frame_q;
  assign FRAME_VALID  = (state_q == PRESENT);
  assign STALL        = (timer_q == TMAX_C);
  assign OVERRUN_SEEN = overrun_q;

`ifdef FIFO_READER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        stall_prev_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      frame_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      stall_prev_q <= 1'b0;
    end else begin
      stall_prev_q <= STALL;
      if (FRAME_VALID && FRAME_READY) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (STALL && !stall_prev_q && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign FRAME_COUNT = frame_cnt_q;
  assign STALL_COUNT = stall_cnt_q;
`endif
endmodule
